user_obi_demux: RTL and testbench

Parametrised user-domain OBI address demultiplexer with an integrated error responder, outstanding-transaction tracking and runtime rule masking. It sits between the user-domain manager port from the crossbar and NumSbr user subordinates, such as the flash controller. It decodes each request against the user address map and steers it to the matching subordinate. Responses return to the manager in order, and unmapped or masked addresses complete with an OBI error.

---
 rtl/croc_pkg.sv | 10 +
 rtl/user_pkg.sv | 22 ++
 rtl/user_obi_err_sbr.sv | 38 +++
 rtl/user_obi_demux.sv | 156 +++++++++++++++
 tb/tb_user_obi_demux.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/croc_pkg.sv
// SoC-wide shared types reused by the domain packages.
package croc_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain address map, subordinate enumeration and error-response payload.
package user_pkg;

  import croc_pkg::*;

  localparam int unsigned NumUserDomainSubordinates = 1;

  typedef enum logic [31:0] {
    UserError = 32'd0,
    UserFlash = 32'd1
  } user_demux_outputs_e;

  localparam logic [31:0] UserFlashStart = 32'h2000_0000;
  localparam logic [31:0] UserFlashEnd   = 32'h2100_0000;

  localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] user_addr_map = '{
    0: '{idx: UserFlash, start_addr: UserFlashStart, end_addr: UserFlashEnd}
  };

  localparam logic [31:0] UserErrData = 32'hBADC_AB1E;

endpackage

// File: rtl/user_obi_err_sbr.sv
// Internal error subordinate: answers every accepted request one cycle later
// with an error, echoing the request aid.
module user_obi_err_sbr import user_pkg::*; #(
  parameter int unsigned IdWidth = 1,
  parameter logic [31:0] ErrData = UserErrData
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic [IdWidth-1:0] aid_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic [IdWidth-1:0] rid_o
);

  logic               valid_q, valid_d;
  logic [IdWidth-1:0] rid_q, rid_d;

  always_comb begin
    valid_d = req_i;
    rid_d   = req_i ? aid_i : rid_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      rid_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rid_q   <= rid_d;
    end
  end

  assign rvalid_o = valid_q;
  assign rdata_o  = valid_q ? ErrData : 32'h0;
  assign rid_o    = valid_q ? rid_q : '0;

endmodule

// File: rtl/user_obi_demux.sv
// User-domain OBI demultiplexer: decodes requests against the address map,
// keeps responses in order by only switching target when nothing is in flight.
module user_obi_demux import user_pkg::*; #(
  parameter int unsigned                          NumSbr   = NumUserDomainSubordinates,
  parameter int unsigned                          NumRules = NumSbr,
  parameter croc_pkg::addr_map_rule_t [NumRules-1:0] AddrMap = user_addr_map,
  parameter int unsigned                          MaxTrans = 4,
  parameter int unsigned                          IdWidth  = 1,
  parameter logic [31:0]                          ErrData  = UserErrData
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumRules-1:0]              rule_en_i,
  input  logic                             mgr_req_i,
  output logic                             mgr_gnt_o,
  input  logic [31:0]                      mgr_addr_i,
  input  logic [31:0]                      mgr_wdata_i,
  input  logic                             mgr_we_i,
  input  logic [3:0]                       mgr_be_i,
  input  logic [IdWidth-1:0]               mgr_aid_i,
  output logic                             mgr_rvalid_o,
  output logic [31:0]                      mgr_rdata_o,
  output logic                             mgr_err_o,
  output logic [IdWidth-1:0]               mgr_rid_o,
  output logic [NumSbr-1:0]                sbr_req_o,
  input  logic [NumSbr-1:0]                sbr_gnt_i,
  output logic [31:0]                      sbr_addr_o,
  output logic [31:0]                      sbr_wdata_o,
  output logic                             sbr_we_o,
  output logic [3:0]                       sbr_be_o,
  output logic [IdWidth-1:0]               sbr_aid_o,
  input  logic [NumSbr-1:0]                sbr_rvalid_i,
  input  logic [NumSbr-1:0][31:0]          sbr_rdata_i,
  input  logic [NumSbr-1:0]                sbr_err_i,
  input  logic [NumSbr-1:0][IdWidth-1:0]   sbr_rid_i,
  output logic [15:0]                      dec_err_cnt_o,
  input  logic                             dec_err_clr_i
);

  localparam int unsigned SelW = $clog2(NumSbr + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [SelW-1:0]    sel, curSel_q, curSel_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [15:0]        errCnt_q, errCnt_d;
  logic               matched, canIssue, accept, errAccept;
  logic               errRvalid;
  logic [31:0]        errRdata;
  logic [IdWidth-1:0] errRid;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_aid_o   = mgr_aid_i;

  // Lowest enabled matching rule wins; out-of-range idx falls back to the error responder.
  always_comb begin
    sel     = '0;
    matched = 1'b0;
    for (int unsigned r = 0; r < NumRules; r++) begin
      if (!matched && rule_en_i[r] &&
          (mgr_addr_i >= AddrMap[r].start_addr) && (mgr_addr_i < AddrMap[r].end_addr)) begin
        matched = 1'b1;
        if ((AddrMap[r].idx != 32'd0) && (AddrMap[r].idx <= NumSbr)) begin
          sel = AddrMap[r].idx[SelW-1:0];
        end
      end
    end
  end

  always_comb begin
    mgr_rvalid_o = errRvalid;
    mgr_rdata_o  = errRdata;
    mgr_err_o    = errRvalid;
    mgr_rid_o    = errRid;
    for (int unsigned k = 0; k < NumSbr; k++) begin
      if (curSel_q == SelW'(k + 1)) begin
        mgr_rvalid_o = sbr_rvalid_i[k];
        mgr_rdata_o  = sbr_rdata_i[k];
        mgr_err_o    = sbr_err_i[k];
        mgr_rid_o    = sbr_rid_i[k];
      end
    end
  end

  // A response retiring this cycle frees a slot, so a full tracker can still accept.
  assign canIssue = ((cnt_q == '0) || (sel == curSel_q)) &&
                    ((cnt_q < CntW'(MaxTrans)) || mgr_rvalid_o);

  always_comb begin
    sbr_req_o = '0;
    mgr_gnt_o = 1'b0;
    if (canIssue) begin
      if (sel == '0) begin
        mgr_gnt_o = 1'b1;
      end
      for (int unsigned k = 0; k < NumSbr; k++) begin
        if (sel == SelW'(k + 1)) begin
          sbr_req_o[k] = mgr_req_i;
          mgr_gnt_o    = sbr_gnt_i[k];
        end
      end
    end
  end

  assign accept    = mgr_req_i && mgr_gnt_o;
  assign errAccept = accept && (sel == '0);

  always_comb begin
    curSel_d = curSel_q;
    cnt_d    = cnt_q;
    errCnt_d = errCnt_q;
    if (accept) begin
      curSel_d = sel;
    end
    if (accept && !mgr_rvalid_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && mgr_rvalid_o && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (dec_err_clr_i) begin
      errCnt_d = '0;
    end else if (errAccept && (errCnt_q != 16'hFFFF)) begin
      errCnt_d = errCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      curSel_q <= '0;
      cnt_q    <= '0;
      errCnt_q <= '0;
    end else begin
      curSel_q <= curSel_d;
      cnt_q    <= cnt_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign dec_err_cnt_o = errCnt_q;

  user_obi_err_sbr #(
    .IdWidth (IdWidth),
    .ErrData (ErrData)
  ) i_err_sbr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (errAccept),
    .aid_i    (mgr_aid_i),
    .rvalid_o (errRvalid),
    .rdata_o  (errRdata),
    .rid_o    (errRid)
  );

endmodule

// File: tb/tb_user_obi_demux.sv
// Randomized bench for user_obi_demux: a flash subordinate model plus an
// in-order response scoreboard derived from the address-map rules.
module tb_user_obi_demux;

  import croc_pkg::*;

  localparam int NumSbr   = 1;
  localparam int NumRules = 2;
  localparam int MaxTrans = 2;
  localparam int IdWidth  = 2;
  localparam logic [31:0] ErrData = 32'hBADC_AB1E;

  localparam addr_map_rule_t [NumRules-1:0] TbMap = '{
    0: '{idx: 32'd1, start_addr: 32'h2000_0000, end_addr: 32'h2100_0000},
    1: '{idx: 32'd5, start_addr: 32'h2080_0000, end_addr: 32'h3000_0000}
  };

  logic [31:0] refStart [NumRules] = '{32'h2000_0000, 32'h2080_0000};
  logic [31:0] refEnd   [NumRules] = '{32'h2100_0000, 32'h3000_0000};
  int          refIdx   [NumRules] = '{1, 5};

  logic clk, rst;
  logic [NumRules-1:0] ruleEn;
  logic mgrReq, mgrGnt, mgrWe, mgrRvalid, mgrErr, decErrClr;
  logic [31:0] mgrAddr, mgrWdata, mgrRdata;
  logic [3:0] mgrBe;
  logic [IdWidth-1:0] mgrAid, mgrRid;
  logic [NumSbr-1:0] sbrReq, sbrGnt, sbrRvalid, sbrErr;
  logic [31:0] sbrAddr, sbrWdata;
  logic sbrWe;
  logic [3:0] sbrBe;
  logic [IdWidth-1:0] sbrAid;
  logic [NumSbr-1:0][31:0] sbrRdata;
  logic [NumSbr-1:0][IdWidth-1:0] sbrRid;
  logic [15:0] decErrCnt;

  user_obi_demux #(
    .NumSbr (NumSbr), .NumRules (NumRules), .AddrMap (TbMap),
    .MaxTrans (MaxTrans), .IdWidth (IdWidth), .ErrData (ErrData)
  ) dut (
    .clk_i (clk), .rst_i (rst), .rule_en_i (ruleEn),
    .mgr_req_i (mgrReq), .mgr_gnt_o (mgrGnt), .mgr_addr_i (mgrAddr),
    .mgr_wdata_i (mgrWdata), .mgr_we_i (mgrWe), .mgr_be_i (mgrBe), .mgr_aid_i (mgrAid),
    .mgr_rvalid_o (mgrRvalid), .mgr_rdata_o (mgrRdata), .mgr_err_o (mgrErr), .mgr_rid_o (mgrRid),
    .sbr_req_o (sbrReq), .sbr_gnt_i (sbrGnt), .sbr_addr_o (sbrAddr), .sbr_wdata_o (sbrWdata),
    .sbr_we_o (sbrWe), .sbr_be_o (sbrBe), .sbr_aid_o (sbrAid),
    .sbr_rvalid_i (sbrRvalid), .sbr_rdata_i (sbrRdata), .sbr_err_i (sbrErr), .sbr_rid_i (sbrRid),
    .dec_err_cnt_o (decErrCnt), .dec_err_clr_i (decErrClr)
  );

  typedef struct {
    bit                 isErr;
    logic [31:0]        data;
    bit                 err;
    logic [IdWidth-1:0] rid;
    int                 ready;
  } rsp_t;

  typedef struct {
    logic [31:0]        data;
    bit                 err;
    logic [IdWidth-1:0] rid;
    int                 due;
  } flash_t;

  rsp_t   expQ[$];
  flash_t flashQ[$];
  bit     rspLog[$];

  int  testsRun = 0;
  int  failures = 0;
  int  cycleNo  = 0;
  int  errCnt   = 0;
  int  lastTgt  = 0;
  int  flashLat = 3;
  bit  flashRespEn = 1;
  bit  hsSeen;
  logic sGnt, sReq, sRv, sErr;
  logic [31:0] sRdata;
  logic [IdWidth-1:0] sRid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycleNo);
    end
  endtask

  function automatic int refDecode(input logic [31:0] a, input logic [NumRules-1:0] en);
    for (int r = 0; r < NumRules; r++) begin
      if (en[r] && (a >= refStart[r]) && (a < refEnd[r])) begin
        return ((refIdx[r] >= 1) && (refIdx[r] <= NumSbr)) ? refIdx[r] : 0;
      end
    end
    return 0;
  endfunction

  function automatic logic [31:0] refData(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  function automatic bit refErr(input logic [31:0] a);
    return (a[7:2] == 6'h3F);
  endfunction

  task automatic applyStimulus(input bit req, input logic [31:0] addr, input bit we,
                               input logic [IdWidth-1:0] aid);
    mgrReq   = req;
    mgrAddr  = addr;
    mgrWe    = we;
    mgrAid   = aid;
    mgrWdata = $urandom;
    mgrBe    = 4'($urandom_range(0, 15));
  endtask

  // One clock cycle: drive the flash model, sample and check, update the models.
  task automatic runCycle();
    int   tgt, n;
    bit   canIssue, expGnt, expReq, expRv, flashDrv;
    rsp_t hd, e;
    flashDrv     = flashRespEn && (flashQ.size() > 0) && (flashQ[0].due <= cycleNo);
    sbrRvalid[0] = flashDrv;
    sbrRdata[0]  = flashDrv ? flashQ[0].data : 32'h0;
    sbrErr[0]    = flashDrv && flashQ[0].err;
    sbrRid[0]    = flashDrv ? flashQ[0].rid : '0;
    #1;
    sGnt = mgrGnt; sReq = sbrReq[0]; sRv = mgrRvalid;
    sErr = mgrErr; sRdata = mgrRdata; sRid = mgrRid;
    if (!rst) begin
      tgt   = refDecode(mgrAddr, ruleEn);
      n     = expQ.size();
      expRv = 1'b0;
      if (n > 0) expRv = expQ[0].isErr ? (expQ[0].ready == cycleNo) : flashDrv;
      canIssue = ((n == 0) || (tgt == lastTgt)) && ((n < MaxTrans) || expRv);
      expGnt   = canIssue && ((tgt == 0) || sbrGnt[0]);
      expReq   = canIssue && (tgt == 1) && mgrReq;
      checkOutput("decErrCnt", decErrCnt, errCnt);
      checkOutput("rvalid", sRv, expRv);
      if (expRv) begin
        hd = expQ.pop_front();
        checkOutput("rdata", sRdata, hd.data);
        checkOutput("rerr", sErr, hd.err);
        checkOutput("rid", sRid, hd.rid);
        rspLog.push_back(sErr);
      end
      if (mgrReq) begin
        checkOutput("gnt", sGnt, expGnt);
        checkOutput("sbrReq", sReq, expReq);
      end
      if (expReq) begin
        checkOutput("sbrAddr", sbrAddr, mgrAddr);
        checkOutput("sbrAid", sbrAid, mgrAid);
        checkOutput("sbrWdata", sbrWdata, mgrWdata);
        checkOutput("sbrBeWe", {sbrBe, sbrWe}, {mgrBe, mgrWe});
      end
      if (decErrClr) errCnt = 0;
      else if (mgrReq && expGnt && (tgt == 0) && (errCnt < 65535)) errCnt++;
      if (mgrReq && expGnt) begin
        e.isErr = (tgt == 0);
        e.data  = (tgt == 0) ? ErrData : refData(mgrAddr);
        e.err   = (tgt == 0) ? 1'b1 : refErr(mgrAddr);
        e.rid   = mgrAid;
        e.ready = cycleNo + 1;
        expQ.push_back(e);
        lastTgt = tgt;
      end
    end
    if (sbrReq[0] && sbrGnt[0]) begin
      flashQ.push_back('{data: refData(mgrAddr), err: refErr(mgrAddr), rid: mgrAid, due: cycleNo + flashLat});
    end
    if (flashDrv) void'(flashQ.pop_front());
    hsSeen = mgrReq && sGnt;
    @(posedge clk);
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic doReset(input int cycles);
    rst       = 1'b1;
    mgrReq    = 1'b0;
    decErrClr = 1'b0;
    repeat (cycles) runCycle();
    rst = 1'b0;
    expQ.delete();
    errCnt  = 0;
    lastTgt = 0;
  endtask

  task automatic holdUntilGrant(input int maxCycles);
    hsSeen = 1'b0;
    for (int i = 0; i < maxCycles && !hsSeen; i++) runCycle();
    checkOutput("grantWait", hsSeen, 1);
    mgrReq = 1'b0;
  endtask

  task automatic drain(input int maxCycles);
    mgrReq = 1'b0;
    for (int i = 0; i < maxCycles && (expQ.size() > 0 || flashQ.size() > 0); i++) runCycle();
    checkOutput("drain", expQ.size() + flashQ.size(), 0);
  endtask

  function automatic logic [31:0] pickAddr();
    case ($urandom_range(0, 7))
      0, 1:    return 32'h2000_0000 + ($urandom & 32'h007F_FFFC);
      2:       return 32'h2080_0000 + ($urandom & 32'h0000_FFFC);
      3:       return 32'h2100_0000;
      4:       return 32'h20FF_FFFC;
      5:       return 32'h2000_0000;
      6:       return 32'h3000_0000 + ($urandom & 32'h0000_0FFC);
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    int grants, stalls;
    ruleEn = 2'b11; sbrGnt = 1'b1; decErrClr = 1'b0; rst = 1'b1;
    sbrRvalid = '0; sbrRdata = '0; sbrErr = '0; sbrRid = '0;
    applyStimulus(0, 32'h0, 0, '0);

    doReset(3);
    #1;
    checkOutput("rstRvalid", mgrRvalid, 0);
    checkOutput("rstErr", mgrErr, 0);
    checkOutput("rstRdata", mgrRdata, 0);
    checkOutput("rstRid", mgrRid, 0);
    checkOutput("rstDecErr", decErrCnt, 0);

    // Mapped flash read, 3-cycle latency.
    flashLat = 3;
    rspLog.delete();
    applyStimulus(1, 32'h2000_0010, 0, 2'd1);
    runCycle();
    checkOutput("t1SbrReq", sReq, 1);
    drain(20);
    checkOutput("t1RspCount", rspLog.size(), 1);

    // Exclusive end of the flash window decodes to the error responder.
    applyStimulus(1, 32'h2100_0000, 0, 2'd2);
    runCycle();
    checkOutput("t2Gnt", sGnt, 1);
    mgrReq = 1'b0;
    runCycle();
    checkOutput("t2Rvalid", sRv, 1);
    checkOutput("t2Err", sErr, 1);
    checkOutput("t2Rdata", sRdata, ErrData);
    checkOutput("t2Rid", sRid, 2);
    checkOutput("t2DecErr", decErrCnt, 1);

    // Disabled rules never match.
    ruleEn = 2'b00;
    applyStimulus(1, 32'h2000_0000, 0, 2'd3);
    runCycle();
    checkOutput("t3SbrReq", sReq, 0);
    mgrReq = 1'b0;
    runCycle();
    checkOutput("t3Err", sErr, 1);
    ruleEn = 2'b11;

    // Tracker full: two grants, third waits for a response and is granted in its cycle.
    flashRespEn = 1'b0;
    grants = 0;
    applyStimulus(1, 32'h2000_0100, 0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      runCycle();
      if (hsSeen) begin
        grants++;
        applyStimulus(1, 32'h2000_0100, 0, 2'(grants));
      end
    end
    checkOutput("t4Grants", grants, 2);
    flashRespEn = 1'b1;
    runCycle();
    checkOutput("t4RvOnFull", sRv, 1);
    checkOutput("t4GntOnRsp", sGnt, 1);
    drain(30);

    // Target switch waits for the flash response; order is flash then error.
    flashLat = 4;
    applyStimulus(1, 32'h2000_0020, 0, 2'd1);
    holdUntilGrant(10);
    rspLog.delete();
    applyStimulus(1, 32'h4000_0000, 0, 2'd2);
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      runCycle();
      if (hsSeen) break;
      stalls++;
    end
    checkOutput("t5Stalls", stalls, 4);
    drain(20);
    checkOutput("t5RspCount", rspLog.size(), 2);
    if (rspLog.size() == 2) begin
      checkOutput("t5FirstFlash", rspLog[0], 0);
      checkOutput("t5SecondErr", rspLog[1], 1);
    end

    // Saturation of the decode-error counter, then clear winning over an increment.
    decErrClr = 1'b1;
    runCycle();
    decErrClr = 1'b0;
    applyStimulus(1, 32'h0000_1000, 0, 2'd1);
    repeat (65540) runCycle();
    checkOutput("t6Saturated", decErrCnt, 16'hFFFF);
    decErrClr = 1'b1;
    runCycle();
    checkOutput("t6ClrAccept", sGnt, 1);
    decErrClr = 1'b0;
    mgrReq = 1'b0;
    checkOutput("t6Cleared", decErrCnt, 0);
    drain(20);

    // Reset with the tracker full discards outstanding state.
    applyStimulus(1, 32'h2000_0040, 0, 2'd0);
    holdUntilGrant(10);
    applyStimulus(1, 32'h2000_0044, 0, 2'd1);
    holdUntilGrant(10);
    doReset(2);
    applyStimulus(1, 32'h0000_2000, 0, 2'd3);
    runCycle();
    checkOutput("t7GntAfterRst", sGnt, 1);
    drain(30);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 2500; i++) begin
      if (!mgrReq && ($urandom_range(0, 3) != 0)) begin
        ruleEn = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        applyStimulus(1, pickAddr(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      sbrGnt[0] = ($urandom_range(0, 3) != 0);
      flashLat  = $urandom_range(1, 4);
      decErrClr = ($urandom_range(0, 40) == 0);
      runCycle();
      if (hsSeen) mgrReq = 1'b0;
    end
    decErrClr = 1'b0;
    sbrGnt[0] = 1'b1;
    drain(50);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
